// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state encoding for the IDLE / RUN / DONE controller
//   - cnt_width(): width of the bit counter for a given operand width
//     ($clog2 of the width, never below one bit)
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder cell.
// Ports:
//   sum  - a ^ b ^ c
//   cout - carry out
//   a, b - operand bits
//   c    - carry in
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic c
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder: one shared full_adder cell is stepped across WIDTH-bit
// operands, LSB first, with the carry held in a register between cycles.
// Operands arrive on a valid/ready handshake; after WIDTH add cycles the sum
// and carry-out are presented on a second valid/ready handshake.
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the ovf output (signed
// overflow of the addition, valid with out_valid).
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - operand pair and cin valid
//   in_ready  - controller idle, can accept operands
//   a, b      - WIDTH-bit operands
//   cin       - carry into the LSB
//   out_valid - sum / cout valid (DONE state)
//   out_ready - consumer takes the result
//   sum       - low WIDTH bits of a + b + cin
//   cout      - bit WIDTH of a + b + cin
//   busy      - high in RUN and DONE
//   ovf       - signed overflow (SERIAL_ADD_OVF_EN only)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_q;
  logic [WIDTH-1:0]   sum_nxt;
  logic               carry_q;
  logic               cout_q;
  logic               fa_sum;
  logic               fa_cout;
  logic               accept;
  logic               last_bit;

  assign accept   = in_valid && (state_q == IDLE);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  full_adder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (carry_q)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    sum_nxt            = sum_q >> 1;
    sum_nxt[WIDTH-1]   = fa_sum;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decode from state only, so no input reaches an output
  // combinationally.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath: operand shift registers, carry, counter, result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      sum_q   <= sum_nxt;
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        cout_q <= fa_cout;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // On the last bit carry_q is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == RUN) && last_bit) begin
      ovf_q <= carry_q ^ fa_cout;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: a WIDTH=8 instance for directed cases and a
// WIDTH=3 instance for an exhaustive sweep. Expected results are computed by
// a reference model when operands are accepted and compared on out_valid.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       iv3, ir3, ov3, or3, cin3, cout3, busy3;
  logic [2:0] a3, b3, sum3;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8, ovf3;
`endif

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
    .a(a3), .b(b3), .cin(cin3), .out_valid(ov3), .out_ready(or3),
    .sum(sum3), .cout(cout3), .busy(busy3)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf3)
`endif
  );

  typedef struct packed {
    logic [8:0] res;
    logic       ovf;
  } exp8_t;

  typedef struct packed {
    logic [3:0] res;
    logic       ovf;
  } exp3_t;

  exp8_t sb8[$];
  exp3_t sb3[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp8_t model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    exp8_t e;
    e.res = {1'b0, x} + {1'b0, y} + {8'd0, c};
    e.ovf = (x[7] == y[7]) && (e.res[7] != x[7]);
    return e;
  endfunction

  function automatic exp3_t model3(input logic [2:0] x, input logic [2:0] y, input logic c);
    exp3_t e;
    e.res = {1'b0, x} + {1'b0, y} + {3'd0, c};
    e.ovf = (x[2] == y[2]) && (e.res[2] != x[2]);
    return e;
  endfunction

  // ---------------- WIDTH=8 helpers ----------------
  task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int n = 0;
    while (!ir8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ir8) chk("w8_in_ready_timeout", 32'(ir8), 32'd1);
    a8 = x; b8 = y; cin8 = c; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    sb8.push_back(model8(x, y, c));
  endtask

  task automatic wait_done8(input string tag);
    int n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1; n++;
      chk({tag, "_in_ready_low"}, 32'(ir8), 32'd0);
      chk({tag, "_busy"}, 32'(busy8), 32'd1);
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
  endtask

  task automatic take8(input string tag);
    exp8_t e;
    if (sb8.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      e = '0;
    end else begin
      e = sb8.pop_front();
    end
    chk({tag, "_out_valid"}, 32'(ov8), 32'd1);
    chk({tag, "_sum"}, 32'(sum8), 32'(e.res[7:0]));
    chk({tag, "_cout"}, 32'(cout8), 32'(e.res[8]));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf8), 32'(e.ovf));
`endif
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk({tag, "_idle_out_valid"}, 32'(ov8), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(ir8), 32'd1);
  endtask

  // ---------------- WIDTH=3 helpers ----------------
  task automatic run3(input logic [2:0] x, input logic [2:0] y, input logic c);
    exp3_t e;
    int n = 0;
    while (!ir3 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ir3) chk("w3_in_ready_timeout", 32'(ir3), 32'd1);
    a3 = x; b3 = y; cin3 = c; iv3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0;
    sb3.push_back(model3(x, y, c));
    n = 0;
    while (!ov3 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("w3_latency", 32'(n), 32'd3);
    e = sb3.pop_front();
    chk("w3_result", 32'({cout3, sum3}), 32'(e.res));
`ifdef SERIAL_ADD_OVF_EN
    chk("w3_ovf", 32'(ovf3), 32'(e.ovf));
`endif
    or3 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    iv3 = 1'b0; or3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready", 32'(ir8), 32'd1);
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(ovf8), 32'd0);
`endif

    // Basic add and carry / overflow corners
    start8(8'h35, 8'h4A, 1'b0); wait_done8("add35_4a"); take8("add35_4a");
    start8(8'hFF, 8'h01, 1'b0); wait_done8("addff_01"); take8("addff_01");
    start8(8'hFF, 8'hFF, 1'b1); wait_done8("addff_ff"); take8("addff_ff");
    start8(8'h7F, 8'h01, 1'b0); wait_done8("add7f_01"); take8("add7f_01");
    start8(8'h80, 8'h80, 1'b0); wait_done8("add80_80"); take8("add80_80");

    // Backpressure in DONE with a competing in_valid
    start8(8'h12, 8'h34, 1'b1);
    wait_done8("bp");
    a8 = 8'h55; b8 = 8'h0A; cin8 = 1'b0; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", 32'(sum8), 32'h47);
      chk("bp_hold_cout", 32'(cout8), 32'd0);
      chk("bp_hold_out_valid", 32'(ov8), 32'd1);
      chk("bp_hold_in_ready", 32'(ir8), 32'd0);
    end
    take8("bp");
    @(posedge clk); #1;
    chk("bp_new_accept_busy", 32'(busy8), 32'd1);
    chk("bp_new_accept_in_ready", 32'(ir8), 32'd0);
    iv8 = 1'b0;
    sb8.push_back(model8(8'h55, 8'h0A, 1'b0));
    wait_done8("bp_new");
    take8("bp_new");

    // Reset in the middle of RUN
    start8(8'hAA, 8'h11, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb8.delete();
    chk("midrst_in_ready", 32'(ir8), 32'd1);
    chk("midrst_out_valid", 32'(ov8), 32'd0);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("midrst_ovf", 32'(ovf8), 32'd0);
`endif
    start8(8'h10, 8'h20, 1'b0); wait_done8("post_rst"); take8("post_rst");

    // WIDTH=3 exhaustive sweep
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      run3(v[2:0], v[5:3], v[6]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
